// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline stages: occupancy encodings and
// the stage state type.
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline register with optional 2-entry skid buffer, synchronous
// flush of control bits and a saturating stall-cycle counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              stat_clear,
  output logic [CNT_W-1:0]  stall_count
);

  pipe_state_t       r_state;
  pipe_state_t       w_state_nxt;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_acc;
  logic              w_con;
  logic              w_load_in;
  logic              w_load_skid;
  logic              w_clear;
  logic [1:0]        w_occ;

  assign w_out_valid = (r_state != EMPTY);
  assign w_acc       = in_valid & w_in_ready;
  assign w_con       = w_out_valid & out_ready;
  assign w_load_in   = w_acc & ((r_state == EMPTY) | ((r_state == ONE) & w_con));
  assign w_load_skid = (r_state == TWO) & w_con;
  assign w_clear     = (r_state == ONE) & w_con & ~w_acc;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: if (w_acc) w_state_nxt = ONE;
        ONE: begin
          // Without a skid register an accept in ONE always coincides with a consume.
          if (w_acc && !w_con)      w_state_nxt = (SKID != 0) ? TWO : ONE;
          else if (!w_acc && w_con) w_state_nxt = EMPTY;
        end
        TWO:     if (w_con) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Control bits are cleared whenever the stage empties so out_ctrl is 0 while invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_main_ctrl <= '0;
      end else if (w_load_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_load_skid) begin
        r_main_ctrl <= w_skid_ctrl;
        r_main_data <= w_skid_data;
      end else if (w_clear) begin
        r_main_ctrl <= '0;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic              r_in_ready;
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [DATA_W-1:0] r_skid_data;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_in_ready  <= 1'b1;
          r_skid_ctrl <= '0;
          r_skid_data <= '0;
        end else begin
          r_in_ready <= (w_state_nxt != TWO);
          if (flush) begin
            r_skid_ctrl <= '0;
          end else if ((r_state == ONE) && w_acc && !w_con) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
          end
        end
      end

      assign w_in_ready  = r_in_ready;
      assign w_skid_ctrl = r_skid_ctrl;
      assign w_skid_data = r_skid_data;
    end else begin : g_noskid
      assign w_in_ready  = ~w_out_valid | out_ready;
      assign w_skid_ctrl = '0;
      assign w_skid_data = '0;
    end
  endgenerate

  always_comb begin
    w_occ = OCC_EMPTY;
    case (r_state)
      ONE:     w_occ = OCC_ONE;
      TWO:     w_occ = OCC_TWO;
      default: w_occ = OCC_EMPTY;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_out_valid & ~out_ready),
    .clr   (stat_clear),
    .count (stall_count)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign occupancy = w_occ;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: skid, saturation and no-skid variants.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // SKID=1, default widths
  logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_stat_clear = 0;
  logic [3:0]  a_in_ctrl = '0, a_out_ctrl;
  logic [31:0] a_in_data = '0, a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;

  // SKID=1, CNT_W=2
  logic s_flush = 0, s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0, s_stat_clear = 0;
  logic [3:0]  s_in_ctrl = '0, s_out_ctrl;
  logic [31:0] s_in_data = '0, s_out_data;
  logic [1:0]  s_occ;
  logic [1:0]  s_stall;

  // SKID=0, DATA_W=64
  logic z_flush = 0, z_in_valid = 0, z_in_ready, z_out_valid, z_out_ready = 0, z_stat_clear = 0;
  logic [3:0]  z_in_ctrl = '0, z_out_ctrl;
  logic [63:0] z_in_data = '0, z_out_data;
  logic [1:0]  z_occ;
  logic [15:0] z_stall;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(4), .SKID(1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ),
    .stat_clear(a_stat_clear), .stall_count(a_stall)
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(4), .SKID(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_ctrl(s_in_ctrl), .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .occupancy(s_occ),
    .stat_clear(s_stat_clear), .stall_count(s_stall)
  );

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(4), .SKID(0), .CNT_W(16)) u_s0 (
    .clk(clk), .reset(reset), .flush(z_flush), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_ctrl(z_in_ctrl), .in_data(z_in_data), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_ctrl(z_out_ctrl), .out_data(z_out_data), .occupancy(z_occ),
    .stat_clear(z_stat_clear), .stall_count(z_stall)
  );

  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  logic [63:0] sbq[$];

  typedef struct {
    logic        iv;
    logic [3:0]  ic;
    logic [31:0] id;
    logic        ordy;
    logic        ev;
    logic [3:0]  ec;
    logic [31:0] ed;
    logic [1:0]  eocc;
    logic        eir;
    logic [15:0] est;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  sat_exp[6];
    logic [63:0] exp_d;

    tbl[0] = '{1'b1, 4'h1, 32'hA, 1'b1, 1'b1, 4'h1, 32'hA, 2'd1, 1'b1, 16'd0};
    tbl[1] = '{1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 4'h1, 32'hA, 2'd1, 1'b1, 16'd1};
    tbl[2] = '{1'b1, 4'h2, 32'hB, 1'b0, 1'b1, 4'h1, 32'hA, 2'd2, 1'b0, 16'd2};
    tbl[3] = '{1'b1, 4'h3, 32'hC, 1'b1, 1'b1, 4'h2, 32'hB, 2'd1, 1'b1, 16'd2};
    tbl[4] = '{1'b1, 4'h3, 32'hC, 1'b1, 1'b1, 4'h3, 32'hC, 2'd1, 1'b1, 16'd2};
    tbl[5] = '{1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 2'd0, 1'b1, 16'd2};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    // reset values
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_ctrl", a_out_ctrl, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_in_ready", a_in_ready, 1);

    // streaming, 1-cycle latency
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_ctrl  = 4'(i);
      a_in_data  = 32'(i);
      #1;
      chk("stream_in_ready", a_in_ready, 1);
      if (a_in_valid && a_in_ready) sbq.push_back(64'(a_in_data));
      step();
      chk("stream_out_valid", a_out_valid, 1);
      if (sbq.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL stream_sb: got output with empty scoreboard");
      end else begin
        exp_d = sbq.pop_front();
        chk("stream_out_data", 64'(a_out_data), exp_d);
      end
    end
    a_in_valid = 1'b0;
    step();
    chk("stream_drain_valid", a_out_valid, 0);
    chk("stream_stall", a_stall, 0);

    // skid fill vectors
    for (int i = 0; i < 6; i++) begin
      a_in_valid  = tbl[i].iv;
      a_in_ctrl   = tbl[i].ic;
      a_in_data   = tbl[i].id;
      a_out_ready = tbl[i].ordy;
      step();
      chk($sformatf("skid%0d_valid", i), a_out_valid, tbl[i].ev);
      chk($sformatf("skid%0d_ctrl", i), a_out_ctrl, tbl[i].ec);
      if (tbl[i].ev) chk($sformatf("skid%0d_data", i), a_out_data, tbl[i].ed);
      chk($sformatf("skid%0d_occ", i), a_occ, tbl[i].eocc);
      chk($sformatf("skid%0d_in_ready", i), a_in_ready, tbl[i].eir);
      chk($sformatf("skid%0d_stall", i), a_stall, tbl[i].est);
    end

    // flush from occupancy 2, with an incoming beat
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 4'hF; a_in_data = 32'h11;
    step();
    a_in_data = 32'h22;
    step();
    chk("fl_pre_occ", a_occ, 2);
    chk("fl_pre_ctrl", a_out_ctrl, 4'hF);
    a_flush = 1'b1; a_in_ctrl = 4'h3; a_in_data = 32'h33;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl_valid", a_out_valid, 0);
    chk("fl_ctrl", a_out_ctrl, 0);
    chk("fl_occ", a_occ, 0);
    chk("fl_in_ready", a_in_ready, 1);
    chk("fl_data_held", a_out_data, 32'h11);
    chk("fl_stall_kept", a_stall, 4);
    step();
    chk("fl_no_ghost", a_out_valid, 0);

    // flush discards a beat accepted in the same cycle
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_ctrl = 4'h5; a_in_data = 32'h44;
    step();
    chk("fl2_pre_valid", a_out_valid, 1);
    a_flush = 1'b1; a_in_ctrl = 4'h3; a_in_data = 32'h66;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl2_valid", a_out_valid, 0);
    chk("fl2_occ", a_occ, 0);
    step();
    chk("fl2_no_ghost", a_out_valid, 0);

    // asynchronous reset with occupancy 2
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 4'h7; a_in_data = 32'h61;
    step();
    a_in_data = 32'h62;
    step();
    a_in_valid = 1'b0;
    chk("ar_pre_occ", a_occ, 2);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", a_out_valid, 0);
    chk("ar_ctrl", a_out_ctrl, 0);
    chk("ar_data", a_out_data, 0);
    chk("ar_occ", a_occ, 0);
    chk("ar_stall", a_stall, 0);
    chk("ar_in_ready", a_in_ready, 1);
    #1 reset = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 4'h1; a_in_data = 32'h55; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    chk("ar_post_valid", a_out_valid, 1);
    chk("ar_post_data", a_out_data, 32'h55);
    step();
    chk("ar_post_empty", a_out_valid, 0);

    // stall counter saturation, CNT_W=2
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_data = 32'h9;
    step();
    s_in_valid = 1'b0;
    chk("sat_start", s_stall, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("sat_%0d", k), s_stall, sat_exp[k]);
    end
    s_stat_clear = 1'b1;
    step();
    s_stat_clear = 1'b0;
    chk("sat_clear", s_stall, 0);
    step();
    chk("sat_after_clear", s_stall, 1);

    // SKID=0 random traffic, then drain
    sbq.delete();
    for (int c = 0; c < 1004; c++) begin
      if (c < 1000) begin
        z_in_valid  = 1'($urandom_range(0, 1));
        z_out_ready = 1'($urandom_range(0, 1));
      end else begin
        z_in_valid  = 1'b0;
        z_out_ready = 1'b1;
      end
      z_in_data = {$urandom, $urandom};
      z_in_ctrl = 4'($urandom);
      #1;
      chk("z_in_ready_rule", z_in_ready, !z_out_valid | z_out_ready);
      chk("z_occ_le1", z_occ <= 2'd1, 1);
      if (z_out_valid && z_out_ready) begin
        if (sbq.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL z_sb: got %0h with empty scoreboard", z_out_data);
        end else begin
          exp_d = sbq.pop_front();
          chk("z_order", z_out_data, exp_d);
        end
      end
      if (z_in_valid && z_in_ready) sbq.push_back(z_in_data);
      step();
    end
    chk("z_no_loss", 64'(sbq.size()), 0);
    chk("z_final_valid", z_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
